// File: rtl/fpu_32_div_pipe.sv
// rtl/fpu_32_div_pipe.sv - pipelined binary32 divider built from reciprocal and multiplier
module fpu_32_reciprocal (
    input  logic [31:0] b,
    output logic [31:0] recip
);
    logic [23:0] m;
    logic [47:0] q;
    logic [7:0]  e;
    logic [22:0] frac;
    logic        unused_q;

    // 1/b for normal b; an exact power of two keeps mantissa 1.0, otherwise 2^47/m lands in (2^23, 2^24)
    always_comb begin
        m    = {1'b1, b[22:0]};
        q    = 48'h8000_0000_0000 / {24'd0, m};
        e    = 8'd0;
        frac = 23'd0;
        if (b[30:23] != 8'h00 && b[30:23] != 8'hFF) begin
            if (b[22:0] == 23'd0) begin
                e = 8'd254 - b[30:23];
            end else begin
                e    = 8'd253 - b[30:23];
                frac = q[22:0];
            end
        end
        recip = (e == 8'd0) ? {b[31], 31'd0} : {b[31], e, frac};
    end

    assign unused_q = ^q[47:23];
endmodule

module fpu_32_multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] product,
    output logic        overflow,
    output logic        underflow
);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       frac;
    logic              s;
    logic              unused_p;

    // Truncating normal x normal product; zero exponent operands are treated as zero
    always_comb begin
        s         = a[31] ^ b[31];
        p         = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e         = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        frac      = p[45:23];
        if (p[47]) begin
            e    = e + 10'sd1;
            frac = p[46:24];
        end
        product   = {s, 31'd0};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (a[30:23] != 8'h00 && b[30:23] != 8'h00) begin
            if (e >= 10'sd255) begin
                overflow = 1'b1;
                product  = {s, 8'hFF, 23'd0};
            end else if (e <= 10'sd0) begin
                underflow = 1'b1;
            end else begin
                product = {s, e[7:0], frac};
            end
        end
    end

    assign unused_p = ^p[22:0];
endmodule

module fpu_32_div_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             invalid,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [2:0]  SP_NONE    = 3'd0;
    localparam logic [2:0]  SP_NAN     = 3'd1;
    localparam logic [2:0]  SP_INF_DBZ = 3'd2;
    localparam logic [2:0]  SP_INF     = 3'd3;
    localparam logic [2:0]  SP_ZERO    = 3'd4;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;

    logic        stall;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [2:0]  code_in;
    logic        v1, v2;
    logic [31:0] a1, b1, a2, r2;
    logic [2:0]  c1, c2;
    logic        s1, s2;
    logic [31:0] recip_s1, prod;
    logic        mul_ovf, mul_unf;
    logic [31:0] res_n;
    logic        inv_n, dbz_n, ovf_n, unf_n;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign a_zero = (a[30:23] == 8'h00);
    assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_zero = (b[30:23] == 8'h00);
    assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

    // Special-case code for the incoming pair, highest priority first
    always_comb begin
        code_in = SP_NONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            code_in = SP_NAN;
        else if (b_zero)
            code_in = a_inf ? SP_INF : SP_INF_DBZ;
        else if (a_inf)
            code_in = SP_INF;
        else if (a_zero || b_inf)
            code_in = SP_ZERO;
    end

    fpu_32_reciprocal u_recip (
        .b     (b1),
        .recip (recip_s1)
    );

    fpu_32_multiplier u_mul (
        .a         (a2),
        .b         (r2),
        .product   (prod),
        .overflow  (mul_ovf),
        .underflow (mul_unf)
    );

    // Final stage value: override on special codes, bubbles zero everything
    always_comb begin
        res_n = 32'd0;
        inv_n = 1'b0;
        dbz_n = 1'b0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        if (v2) begin
            case (c2)
                SP_NAN:     begin res_n = QNAN;                 inv_n = 1'b1; end
                SP_INF_DBZ: begin res_n = {s2, 8'hFF, 23'd0};   dbz_n = 1'b1; end
                SP_INF:     res_n = {s2, 8'hFF, 23'd0};
                SP_ZERO:    res_n = {s2, 31'd0};
                default:    begin res_n = prod; ovf_n = mul_ovf; unf_n = mul_unf; end
            endcase
        end
    end

    // Three-stage pipeline advancing together unless the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            a1          <= 32'd0;
            b1          <= 32'd0;
            c1          <= SP_NONE;
            s1          <= 1'b0;
            v2          <= 1'b0;
            a2          <= 32'd0;
            r2          <= 32'd0;
            c2          <= SP_NONE;
            s2          <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (!stall) begin
            v1          <= in_valid;
            a1          <= a;
            b1          <= b;
            c1          <= code_in;
            s1          <= a[31] ^ b[31];
            v2          <= v1;
            a2          <= a1;
            r2          <= recip_s1;
            c2          <= c1;
            s2          <= s1;
            out_valid   <= v2;
            result      <= res_n;
            invalid     <= inv_n;
            div_by_zero <= dbz_n;
            overflow    <= ovf_n;
            underflow   <= unf_n;
        end
    end
endmodule

// File: tb/tb_fpu_32_div_pipe.sv
// tb/tb_fpu_32_div_pipe.sv - directed table and sequence bench for fpu_32_div_pipe
module tb_fpu_32_div_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero, invalid, overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        int          tol;
    } vec_t;

    localparam int NV = 14;
    vec_t vt[NV];

    fpu_32_div_pipe #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .invalid     (invalid),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flags();
        return {28'd0, invalid, div_by_zero, overflow, underflow};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
        int diff;
        n_checks++;
        diff = int'({1'b0, act[30:0]}) - int'({1'b0, exp[30:0]});
        if (diff < 0) diff = -diff;
        if (act[31] !== exp[31] || diff > tol || $isunknown(act)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (+/-%0d ulp)", name, act, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int issued, got, cyc, last_fire;
        logic [31:0] bp_exp[4];
        logic        bub_pat[3];

        vt[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 2};
        vt[1]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0};
        vt[2]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0};
        vt[3]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 0};
        vt[4]  = '{32'hBF800000, 32'h7F800000, 32'h80000000, 4'b0000, 0};
        vt[5]  = '{32'hFF000000, 32'h00800000, 32'hFF800000, 4'b0010, 0};
        vt[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0};
        vt[7]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 0};
        vt[8]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 4'b0000, 0};
        vt[9]  = '{32'hFF800000, 32'h00000000, 32'hFF800000, 4'b0000, 0};
        vt[10] = '{32'h40C00000, 32'hC0000000, 32'hC0400000, 4'b0000, 2};
        vt[11] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 2};
        vt[12] = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 0};
        vt[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0};

        // reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        step(); step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", flags(), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // latency of a single divide
        in_valid = 1'b1; a = 32'h40C00000; b = 32'h40000000;
        step();
        in_valid = 1'b0;
        check("lat_c1", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_c2", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_c3", {31'd0, out_valid}, 32'd1);
        check_near("lat_result", result, 32'h40400000, 2);
        check("lat_flags", flags(), 32'd0);
        step();

        // table vectors issued back-to-back
        issued = 0; got = 0; cyc = 0;
        while (got < NV && cyc < 100) begin
            in_valid = (issued < NV);
            if (issued < NV) begin a = vt[issued].a; b = vt[issued].b; end
            #1;
            if (out_valid && got < NV) begin
                check_near($sformatf("tbl%0d_res", got), result, vt[got].res, vt[got].tol);
                check($sformatf("tbl%0d_flg", got), flags(), {28'd0, vt[got].flg});
                got++;
            end
            if (in_valid && in_ready) issued++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("tbl_count", got, NV);
        repeat (3) step();

        // backpressure: four divides, consumer stalls for six cycles
        bp_exp[0] = 32'h3F800000; bp_exp[1] = 32'h40000000;
        bp_exp[2] = 32'h40400000; bp_exp[3] = 32'h40800000;
        issued = 0; got = 0; cyc = 0; last_fire = -1;
        while (got < 4 && cyc < 40) begin
            out_ready = (cyc >= 6);
            in_valid  = (issued < 4);
            if (issued < 4) a = bp_exp[issued];
            b = 32'h3F800000;
            #1;
            if (out_valid && !out_ready) begin
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_hold", result, 32'h3F800000);
            end
            if (out_valid && out_ready) begin
                check($sformatf("bp_out%0d", got), result, bp_exp[got]);
                if (got > 0) check("bp_consec", cyc - last_fire, 1);
                last_fire = cyc;
                got++;
            end
            if (in_valid && in_ready) issued++;
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", got, 4);
        #1;
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);
        repeat (3) step();

        // bubbles: in_valid 1,0,1 -> out_valid 1,0,1 three cycles later
        bub_pat[0] = 1'b1; bub_pat[1] = 1'b0; bub_pat[2] = 1'b1;
        a = 32'h40C00000; b = 32'h40000000;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3) ? bub_pat[i] : 1'b0;
            #1;
            if (i >= 3) check($sformatf("bub_v%0d", i - 3), {31'd0, out_valid}, {31'd0, bub_pat[i - 3]});
            if (i == 4) check("bub_flags", flags(), 32'd0);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // reset while two divides are in flight
        in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000;
        step();
        a = 32'h40400000;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("post_rst_ov%0d", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("post_rst_ir%0d", i), {31'd0, in_ready}, 32'd1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
